mac_table_assoc: RTL and testbench

Parametrised successor to the single-port MAC learning block: a set-associative MAC learning and lookup table for an N-port switch, with periodic aging. It sits between the ingress parser and the forwarding crossbar. Per frame it takes (src_port, src_mac, dst_mac) over a valid/ready handshake, looks up the destination, learns the source, and returns an egress port mask: unicast, flood or filter.

---
 rtl/mac_learning_pkg.sv | 39 +++
 rtl/mac_table_way_ram.sv | 26 ++
 rtl/mac_table_assoc.sv | 226 ++++++++++++++++++++++
 tb/tb_mac_table_assoc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_learning_pkg.sv
// rtl/mac_learning_pkg.sv - shared types, constants and hash for the MAC learning table
// Purpose: MAC width, I/G bit position, table entry layout, FSM states and the set-index hash.
// Ports: none (package).
package mac_learning_pkg;

  localparam int MAC_W = 48;
  localparam int IG_BIT = 40;

  // Upper bounds for the per-entry port and age fields; the top zero-extends into them.
  localparam int ENTRY_PORT_W = 8;
  localparam int ENTRY_AGE_W = 8;

  typedef struct packed {
    logic [MAC_W-1:0]        mac;
    logic [ENTRY_PORT_W-1:0] port;
    logic [ENTRY_AGE_W-1:0]  age;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DST,
    ST_CMP_DST,
    ST_CMP_SRC,
    ST_RESP,
    ST_SWP_RD,
    ST_SWP_WR
  } state_t;

  // XOR of addr_w-bit chunks; folding bit i onto bit (i mod addr_w) is the same fold.
  function automatic logic [MAC_W-1:0] mac_hash(input logic [MAC_W-1:0] mac, input int addr_w);
    logic [MAC_W-1:0] h;
    h = '0;
    for (int i = 0; i < MAC_W; i++) begin
      h[i % addr_w] = h[i % addr_w] ^ mac[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/mac_table_way_ram.sv
// rtl/mac_table_way_ram.sv - one way of the table: simple dual-port entry RAM
// Purpose: holds mac/port/age for one way of every set; 1-cycle registered read, no reset.
// Ports: clk; rd_addr/rd_data read port; wr_en/wr_addr/wr_data write port.
module mac_table_way_ram
  import mac_learning_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data
);

  entry_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mac_table_assoc.sv
// rtl/mac_table_assoc.sv - set-associative MAC learning/lookup table with aging
// Purpose: per frame, look up dst, learn src, return egress port mask; periodic age sweep; flush.
// Ports: clk, rst (sync, active-high); req_valid/req_ready with src_port, src_mac, dst_mac;
//        resp_valid strobe with resp_hit, resp_port_mask; flush level request.
module mac_table_assoc
  import mac_learning_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = 8,
  parameter int WAYS = 2,
  parameter int AGE_W = 8,
  parameter int AGE_MAX = 200,
  parameter int TICK_DIV = 1000000,
  localparam int PORT_W = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PORT_W-1:0]    src_port,
  input  logic [MAC_W-1:0]     src_mac,
  input  logic [MAC_W-1:0]     dst_mac,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [NUM_PORTS-1:0] resp_port_mask,
  input  logic                 flush
);

  localparam int SETS = 2**ADDR_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  state_t state, state_nxt;
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [PORT_W-1:0] src_port_q;
  logic [MAC_W-1:0] src_mac_q, dst_mac_q;
  logic dst_hit_q, resp_hit_q, dst_hit_d;
  logic [NUM_PORTS-1:0] dst_mask_q, resp_mask_q, dst_mask_d, flood;
  logic [TICK_W-1:0] tick_q;
  logic tick_wrap, sweep_pending_q, sweeping, port_ok, learn_en;
  logic [ADDR_W-1:0] swp_set_q, dst_set, src_set, cmp_set, rd_addr, wr_addr;
  logic [MAC_W-1:0] cmp_mac;
  logic [WAYS-1:0] way_hit, wr_en, expire, set_valid;
  logic [WAY_W-1:0] hit_way, lrn_way;
  logic [ENTRY_PORT_W-1:0] hit_port;
  logic [ENTRY_AGE_W-1:0] max_age;
  logic [ENTRY_AGE_W-1:0] aged [WAYS];
  entry_t rd_data [WAYS];
  entry_t wr_data [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    mac_table_way_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .rd_addr (rd_addr),
      .rd_data (rd_data[w]),
      .wr_en   (wr_en[w]),
      .wr_addr (wr_addr),
      .wr_data (wr_data[w])
    );
  end

  assign dst_set   = ADDR_W'(mac_hash(dst_mac_q, ADDR_W));
  assign src_set   = ADDR_W'(mac_hash(src_mac_q, ADDR_W));
  assign port_ok   = int'(src_port_q) < NUM_PORTS;
  assign flood     = ~(NUM_PORTS'(1) << src_port_q);
  assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
  assign sweeping  = (state == ST_SWP_RD) || (state == ST_SWP_WR);
  assign learn_en  = (state == ST_CMP_SRC) && port_ok && !src_mac_q[IG_BIT];
  assign set_valid = valid_q[src_set];

  assign req_ready      = !rst && (state == ST_IDLE) && !flush && !sweep_pending_q;
  assign resp_valid     = !rst && (state == ST_RESP);
  assign resp_hit       = !rst && resp_hit_q;
  assign resp_port_mask = rst ? '0 : resp_mask_q;

  // RAM read address: dst set, then src set (read in CMP_DST lands in CMP_SRC), or sweep set.
  always_comb begin
    rd_addr = dst_set;
    case (state)
      ST_CMP_DST: rd_addr = src_set;
      ST_SWP_RD:  rd_addr = swp_set_q;
      default:    rd_addr = dst_set;
    endcase
  end

  // One comparator bank serves both the dst lookup and the src learn check.
  always_comb begin
    cmp_set = (state == ST_CMP_DST) ? dst_set : src_set;
    cmp_mac = (state == ST_CMP_DST) ? dst_mac_q : src_mac_q;
    way_hit = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[cmp_set][w] && (rd_data[w].mac == cmp_mac);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  always_comb begin
    hit_port   = rd_data[hit_way].port;
    dst_hit_d  = 1'b0;
    dst_mask_d = '0;
    if (port_ok) begin
      dst_mask_d = flood;
      if (!dst_mac_q[IG_BIT] && (|way_hit)) begin
        dst_hit_d  = 1'b1;
        dst_mask_d = (hit_port == ENTRY_PORT_W'(src_port_q)) ? '0 : (NUM_PORTS'(1) << hit_port);
      end
    end
  end

  // Learn target: existing entry, else lowest invalid way, else oldest (lowest index on ties).
  always_comb begin
    lrn_way = hit_way;
    max_age = rd_data[0].age;
    if (!(|way_hit)) begin
      if (!(&set_valid)) begin
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (!set_valid[w]) lrn_way = WAY_W'(w);
        end
      end else begin
        lrn_way = '0;
        for (int w = 1; w < WAYS; w++) begin
          if (rd_data[w].age > max_age) begin
            max_age = rd_data[w].age;
            lrn_way = WAY_W'(w);
          end
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      aged[w]   = rd_data[w].age + 1'b1;
      expire[w] = valid_q[swp_set_q][w] && (int'(aged[w]) >= AGE_MAX);
    end
  end

  always_comb begin
    wr_addr = src_set;
    wr_en   = '0;
    for (int w = 0; w < WAYS; w++) begin
      wr_data[w] = '{mac: src_mac_q, port: ENTRY_PORT_W'(src_port_q), age: '0};
    end
    if (state == ST_SWP_WR) begin
      wr_addr = swp_set_q;
      for (int w = 0; w < WAYS; w++) begin
        wr_en[w]       = valid_q[swp_set_q][w];
        wr_data[w]     = rd_data[w];
        wr_data[w].age = ENTRY_AGE_W'(aged[w][AGE_W-1:0]);
      end
    end else if (learn_en) begin
      wr_en[lrn_way] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush)                state_nxt = ST_IDLE;
        else if (sweep_pending_q) state_nxt = ST_SWP_RD;
        else if (req_valid)       state_nxt = ST_RD_DST;
      end
      ST_RD_DST:  state_nxt = ST_CMP_DST;
      ST_CMP_DST: state_nxt = ST_CMP_SRC;
      ST_CMP_SRC: state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      ST_SWP_RD:  state_nxt = ST_SWP_WR;
      ST_SWP_WR:  state_nxt = (&swp_set_q) ? ST_IDLE : ST_SWP_RD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      valid_q         <= '0;
      tick_q          <= '0;
      sweep_pending_q <= 1'b0;
      swp_set_q       <= '0;
      src_port_q      <= '0;
      src_mac_q       <= '0;
      dst_mac_q       <= '0;
      dst_hit_q       <= 1'b0;
      dst_mask_q      <= '0;
      resp_hit_q      <= 1'b0;
      resp_mask_q     <= '0;
    end else begin
      state  <= state_nxt;
      tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
      // A tick while a sweep is pending or running is merged into it.
      if (tick_wrap && !sweep_pending_q && !sweeping) begin
        sweep_pending_q <= 1'b1;
      end else if (state == ST_IDLE && !flush && sweep_pending_q) begin
        sweep_pending_q <= 1'b0;
      end
      if (req_valid && req_ready) begin
        src_port_q <= src_port;
        src_mac_q  <= src_mac;
        dst_mac_q  <= dst_mac;
      end
      if (state == ST_IDLE && flush) begin
        valid_q <= '0;
      end
      if (state == ST_CMP_DST) begin
        dst_hit_q  <= dst_hit_d;
        dst_mask_q <= dst_mask_d;
      end
      if (state == ST_CMP_SRC) begin
        resp_hit_q  <= dst_hit_q;
        resp_mask_q <= dst_mask_q;
        if (learn_en) valid_q[src_set][lrn_way] <= 1'b1;
      end
      if (state == ST_SWP_WR) begin
        for (int w = 0; w < WAYS; w++) begin
          if (expire[w]) valid_q[swp_set_q][w] <= 1'b0;
        end
        swp_set_q <= swp_set_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_table_assoc.sv
// tb/tb_mac_table_assoc.sv - self-checking bench for mac_table_assoc
module tb_mac_table_assoc;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W = 2;
  localparam int WAYS = 2;
  localparam int AGE_W = 8;
  localparam int AGE_MAX = 3;
  localparam int TICK_DIV = 50;
  localparam int SETS = 1 << ADDR_W;

  localparam logic [47:0] MAC_A  = 48'h0000_0000_0001;
  localparam logic [47:0] MAC_B  = 48'h0000_0000_0010;
  localparam logic [47:0] MAC_C  = 48'h0000_0000_0100;
  localparam logic [47:0] MAC_MC = 48'h0100_5e00_0001;
  localparam logic [47:0] BCAST  = 48'hffff_ffff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic flush = 1'b0;
  logic [1:0] src_port = '0;
  logic [47:0] src_mac = '0;
  logic [47:0] dst_mac = '0;
  logic req_ready, resp_valid, resp_hit;
  logic [3:0] resp_port_mask;

  int n_checks = 0;
  int n_errors = 0;

  mac_table_assoc #(
    .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .WAYS(WAYS),
    .AGE_W(AGE_W), .AGE_MAX(AGE_MAX), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .src_port(src_port), .src_mac(src_mac), .dst_mac(dst_mac),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_port_mask(resp_port_mask),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit          v;
    logic [47:0] mac;
    int          port;
    int          age;
  } ment_t;

  ment_t tbl [SETS][WAYS];
  int m_busy = 0;        // remaining non-idle cycles of the current operation
  bit m_is_req = 0;      // current operation is a frame (else a sweep)
  int m_tick = 0;
  bit m_pend = 0;
  bit m_pr_hit = 0, m_exp_hit = 0;
  logic [3:0] m_pr_mask = '0, m_exp_mask = '0;

  function automatic int m_hash(input logic [47:0] mac);
    int h = 0;
    for (int k = 0; k < 48; k += ADDR_W) h ^= int'((mac >> k) & 48'((1 << ADDR_W) - 1));
    return h;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) tbl[s][w].v = 0;
  endfunction

  function automatic void m_sweep();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (tbl[s][w].v) begin
          tbl[s][w].age++;
          if (tbl[s][w].age >= AGE_MAX) tbl[s][w].v = 0;
        end
  endfunction

  function automatic void m_request(input int sp, input logic [47:0] s, input logic [47:0] d);
    int ds, ss, victim;
    logic [3:0] flood;
    flood = 4'hF & ~(4'b0001 << sp);
    m_pr_hit = 0;
    m_pr_mask = '0;
    if (sp >= NUM_PORTS) return;
    m_pr_mask = flood;
    if (!d[40]) begin
      ds = m_hash(d);
      for (int w = 0; w < WAYS; w++)
        if (tbl[ds][w].v && tbl[ds][w].mac == d) begin
          m_pr_hit = 1;
          m_pr_mask = (tbl[ds][w].port == sp) ? 4'b0000 : (4'b0001 << tbl[ds][w].port);
          break;
        end
    end
    if (s[40]) return;
    ss = m_hash(s);
    victim = -1;
    for (int w = 0; w < WAYS; w++)
      if (victim < 0 && tbl[ss][w].v && tbl[ss][w].mac == s) victim = w;
    for (int w = 0; w < WAYS; w++)
      if (victim < 0 && !tbl[ss][w].v) victim = w;
    if (victim < 0) begin
      victim = 0;
      for (int w = 1; w < WAYS; w++)
        if (tbl[ss][w].age > tbl[ss][victim].age) victim = w;
    end
    tbl[ss][victim].v = 1;
    tbl[ss][victim].mac = s;
    tbl[ss][victim].port = sp;
    tbl[ss][victim].age = 0;
  endfunction

  always @(posedge clk) begin
    bit was_sweeping, tick_fire, start_sw;
    if (rst) begin
      m_clear();
      m_busy = 0; m_tick = 0; m_pend = 0;
      m_exp_hit = 0; m_exp_mask = '0;
    end else begin
      was_sweeping = (m_busy > 0) && !m_is_req;
      tick_fire = (m_tick == TICK_DIV - 1);
      start_sw = 0;
      m_tick = tick_fire ? 0 : m_tick + 1;
      if (m_busy == 0) begin
        if (flush) m_clear();
        else if (m_pend) begin
          start_sw = 1; m_sweep(); m_busy = 2 * SETS; m_is_req = 0;
        end else if (req_valid) begin
          m_request(int'(src_port), src_mac, dst_mac); m_busy = 4; m_is_req = 1;
        end
      end else begin
        m_busy--;
        if (m_is_req && m_busy == 1) begin
          m_exp_hit = m_pr_hit;
          m_exp_mask = m_pr_mask;
        end
      end
      if (tick_fire && !m_pend && !was_sweeping) m_pend = 1;
      else if (start_sw) m_pend = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_mask", resp_port_mask, 0);
    end else begin
      chk("req_ready", req_ready, (m_busy == 0) && !flush && !m_pend);
      chk("resp_valid", resp_valid, m_is_req && (m_busy == 1));
      if (m_is_req && m_busy == 1) begin
        chk("resp_hit", resp_hit, m_exp_hit);
        chk("resp_mask", resp_port_mask, m_exp_mask);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) break;
    end
    chk("accept_in_time", n <= 100, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic send(input int p, input logic [47:0] s, input logic [47:0] d,
                      output logic h, output logic [3:0] m, output int lat);
    @(posedge clk);
    #1 req_valid = 1'b1; src_port = 2'(p); src_mac = s; dst_mac = d;
    wait_accept();
    lat = 0; h = 1'bx; m = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n; h = resp_hit; m = resp_port_mask;
        break;
      end
    end
  endtask

  task automatic expect_frame(input string name, input int p, input logic [47:0] s,
                              input logic [47:0] d, input logic eh, input logic [3:0] em);
    logic h;
    logic [3:0] m;
    int lat;
    send(p, s, d, h, m, lat);
    chk({name, "_latency"}, lat, 4);
    chk({name, "_hit"}, h, eh);
    chk({name, "_mask"}, m, em);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic h;
    logic [3:0] m;
    int lat, cnt, run, n_runs;
    bit prev_rdy, in_run;

    chk("model_hash_A", m_hash(MAC_A), 1);
    chk("model_hash_B", m_hash(MAC_B), 1);
    chk("model_hash_C", m_hash(MAC_C), 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Learn then forward
    expect_frame("learn_fwd1", 1, 48'h0011_2233_4455, 48'h6677_8899_aabb, 0, 4'b1101);
    expect_frame("learn_fwd2", 2, 48'h6677_8899_aabb, 48'h0011_2233_4455, 1, 4'b0010);

    // Multicast: never learned, always flooded
    expect_frame("bcast", 0, 48'h0011_2233_4455, BCAST, 0, 4'b1110);
    expect_frame("mc_src", 3, MAC_MC, BCAST, 0, 4'b0111);
    expect_frame("mc_dst", 0, 48'h0011_2233_4455, MAC_MC, 0, 4'b1110);

    // Replacement: A ages by one sweep, then B and C fill set 1 and C evicts A
    do_reset();
    expect_frame("repl_learn_a", 1, MAC_A, BCAST, 0, 4'b1101);
    repeat (60) @(posedge clk);
    expect_frame("repl_learn_b", 2, MAC_B, BCAST, 0, 4'b1011);
    expect_frame("repl_learn_c", 3, MAC_C, BCAST, 0, 4'b0111);
    expect_frame("repl_look_a", 0, MAC_MC, MAC_A, 0, 4'b1110);
    expect_frame("repl_look_b", 0, MAC_MC, MAC_B, 1, 4'b0100);
    expect_frame("repl_look_c", 0, MAC_MC, MAC_C, 1, 4'b1000);

    // Aging: A expires after AGE_MAX sweeps; ready is low for one pending cycle plus the sweep
    do_reset();
    expect_frame("age_learn_a", 1, MAC_A, BCAST, 0, 4'b1101);
    @(negedge clk);
    prev_rdy = req_ready; in_run = 0; run = 0; n_runs = 0;
    repeat (200) begin
      @(negedge clk);
      if (!req_ready) begin
        if (prev_rdy) begin in_run = 1; run = 0; end
        if (in_run) run++;
      end else if (in_run) begin
        chk("sweep_ready_low_cycles", run, 2 * SETS + 1);
        in_run = 0;
        n_runs++;
      end
      prev_rdy = req_ready;
    end
    chk("sweeps_seen_ge3", n_runs >= 3, 1);
    expect_frame("age_look_a", 0, MAC_MC, MAC_A, 0, 4'b1110);

    // Station move and same-port filter
    do_reset();
    expect_frame("move_learn1", 1, MAC_A, BCAST, 0, 4'b1101);
    expect_frame("move_learn3", 3, MAC_A, BCAST, 0, 4'b0111);
    expect_frame("filter_p3", 3, MAC_MC, MAC_A, 1, 4'b0000);
    expect_frame("move_p0", 0, MAC_MC, MAC_A, 1, 4'b1000);

    // Reset one cycle after accept aborts the frame and empties the table
    do_reset();
    expect_frame("rst_learn_a", 1, MAC_A, BCAST, 0, 4'b1101);
    expect_frame("rst_learn_b", 2, MAC_B, BCAST, 0, 4'b1011);
    @(posedge clk);
    #1 req_valid = 1'b1; src_port = 2'd0; src_mac = MAC_MC; dst_mac = MAC_A;
    wait_accept();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("no_resp_after_reset", cnt, 0);
    expect_frame("rst_look_a", 0, MAC_MC, MAC_A, 0, 4'b1110);
    expect_frame("rst_look_b", 0, MAC_MC, MAC_B, 0, 4'b1110);

    // Flush in IDLE
    do_reset();
    expect_frame("flush_learn_a", 1, MAC_A, BCAST, 0, 4'b1101);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!req_ready && cnt < 50);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    expect_frame("flush_look_a", 0, MAC_MC, MAC_A, 0, 4'b1110);

    // Randomised traffic over a small MAC pool, with flush pulses and long idle gaps
    do_reset();
    begin
      logic [47:0] pool [10];
      pool = '{MAC_A, MAC_B, MAC_C, 48'h2, 48'h3, 48'h4, 48'h8, 48'h5, BCAST, MAC_MC};
      for (int i = 0; i < 250; i++) begin
        send(int'($urandom_range(0, 3)), pool[$urandom_range(0, 9)],
             pool[$urandom_range(0, 9)], h, m, lat);
        chk("rand_latency", lat, 4);
        if ($urandom_range(0, 19) == 0) begin
          @(posedge clk); #1 flush = 1'b1;
          @(posedge clk); #1 flush = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) repeat ($urandom_range(20, 70)) @(posedge clk);
        else repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", n_errors);
    $fatal(1, "time limit");
  end

endmodule
